// File: rtl/bus_transfer_ctrl.sv
// Shared-bus move sequencer: accepts one register or immediate move at a time and drives
// one-hot load/save enables so exactly one source owns the bus while the destination captures.
module bus_transfer_ctrl #(
  parameter int unsigned NUM_REGS = 6,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                clk,
  input  logic                res,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_src,
  input  logic [SEL_W-1:0]    req_dst,
  input  logic                req_imm_en,
  input  logic [7:0]          req_imm,
  input  logic [7:0]          bus_in,
  output logic [7:0]          bus_drive,
  output logic [NUM_REGS-1:0] load_enable,
  output logic [NUM_REGS-1:0] save_enable,
  output logic                done,
  output logic                error,
  output logic [7:0]          xfer_count,
  output logic [7:0]          last_value
);

  typedef enum logic [2:0] {StIdle, StDrive, StWrite, StDone, StErr} state_e;

  state_e                state_q;
  logic [SEL_W-1:0]      dst_q;
  logic [7:0]            imm_q;
  logic                  drive_en_q;
  logic [NUM_REGS-1:0]   load_q;
  logic [NUM_REGS-1:0]   save_q;
  logic                  done_q;
  logic                  error_q;
  logic [7:0]            count_q;
  logic [7:0]            last_q;
  logic                  bad_req;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // A register source is only range-checked when it will actually drive the bus.
  assign bad_req = (32'(req_dst) >= NUM_REGS) || (!req_imm_en && (32'(req_src) >= NUM_REGS));

  // Enables are registered on the transition into each state, so they reflect the request
  // as latched at the accept edge and never follow the live req_* inputs afterwards.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= StIdle;
      dst_q      <= '0;
      imm_q      <= '0;
      drive_en_q <= 1'b0;
      load_q     <= '0;
      save_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      last_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            dst_q <= req_dst;
            imm_q <= req_imm;
            if (bad_req) begin
              state_q <= StErr;
              error_q <= 1'b1;
            end else begin
              state_q    <= StDrive;
              drive_en_q <= req_imm_en;
              load_q     <= req_imm_en ? '0 : onehot(req_src);
            end
          end
        end
        StDrive: begin
          state_q <= StWrite;
          save_q  <= onehot(dst_q);
        end
        StWrite: begin
          state_q    <= StDone;
          last_q     <= bus_in;
          drive_en_q <= 1'b0;
          load_q     <= '0;
          save_q     <= '0;
          done_q     <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          count_q <= count_q + 8'd1;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          drive_en_q <= 1'b0;
          load_q     <= '0;
          save_q     <= '0;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign bus_drive   = drive_en_q ? imm_q : 8'bzzzzzzzz;
  assign load_enable = load_q;
  assign save_enable = save_q;
  assign done        = done_q;
  assign error       = error_q;
  assign xfer_count  = count_q;
  assign last_value  = last_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: models the register slices on the bus and scoreboards each
// accepted request against its completion (done/error, captured byte, destination contents).
module tb_bus_transfer_ctrl;
  localparam int unsigned NR = 6;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          res;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_src;
  logic [SW-1:0] req_dst;
  logic          req_imm_en;
  logic [7:0]    req_imm;
  logic [7:0]    bus_in;
  wire  [7:0]    bus_drive;
  logic [NR-1:0] load_enable;
  logic [NR-1:0] save_enable;
  logic          done;
  logic          error;
  logic [7:0]    xfer_count;
  logic [7:0]    last_value;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic       err;
    logic [2:0] dst;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] slice [NR];
  logic [7:0] mdl [NR];

  bus_transfer_ctrl #(.NUM_REGS(NR), .SEL_W(SW)) dut (
    .clk        (clk),
    .res        (res),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_imm_en (req_imm_en),
    .req_imm    (req_imm),
    .bus_in     (bus_in),
    .bus_drive  (bus_drive),
    .load_enable(load_enable),
    .save_enable(save_enable),
    .done       (done),
    .error      (error),
    .xfer_count (xfer_count),
    .last_value (last_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus resolution: a slice with its load enable owns the bus, otherwise the controller.
  always_comb begin
    bus_in = bus_drive;
    for (int i = 0; i < NR; i++) begin
      if (load_enable[i]) bus_in = slice[i];
    end
  end

  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NR; i++) slice[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (save_enable[i]) slice[i] <= bus_in;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!res) begin
      vectors++;
      if (!$onehot0(load_enable) || !$onehot0(save_enable)) begin
        miscompares++;
        $display("FAIL enable_onehot load=%b save=%b required at most one bit each",
                 load_enable, save_enable);
      end
      if (done || error) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_completion done=%b error=%b required no pulse", done, error);
        end else begin
          e = exp_q.pop_front();
          if (error !== e.err || done !== !e.err) begin
            miscompares++;
            $display("FAIL completion_kind done=%b error=%b required error=%b", done, error, e.err);
          end
          if (!e.err) begin
            vectors++;
            if (last_value !== e.val) begin
              miscompares++;
              $display("FAIL last_value got %h required %h", last_value, e.val);
            end
            vectors++;
            if (slice[e.dst] !== e.val) begin
              miscompares++;
              $display("FAIL dst_slice[%0d] got %h required %h", e.dst, slice[e.dst], e.val);
            end
          end
        end
      end
    end
  end

  function automatic void push_exp(input logic [2:0] src, input logic [2:0] dst,
                                   input logic imm_en, input logic [7:0] imm);
    exp_t e;
    e.err = (32'(dst) >= NR) || (!imm_en && (32'(src) >= NR));
    e.dst = dst;
    e.val = imm_en ? imm : (e.err ? 8'h00 : mdl[src]);
    if (!e.err) mdl[dst] = e.val;
    exp_q.push_back(e);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    exp_q.delete();
  endtask

  // Returns just after the accept edge; the next negedge is mid-cycle 1.
  task automatic send(input logic [2:0] src, input logic [2:0] dst, input logic imm_en,
                      input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
    end else begin
      req_valid  = 1'b1;
      req_src    = src;
      req_dst    = dst;
      req_imm_en = imm_en;
      req_imm    = imm;
      @(posedge clk);
      push_exp(src, dst, imm_en, imm);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(req_ready && exp_q.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(req_ready && exp_q.size() == 0)) begin
      miscompares++;
      $display("FAIL idle_timeout req_ready=%b pending=%0d required ready, 0 pending",
               req_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    req_valid = 1'b0;
    req_src = '0;
    req_dst = '0;
    req_imm_en = 1'b0;
    req_imm = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, done, error} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl ready/done/error=%b required 100", {req_ready, done, error});
    end
    vectors++;
    if ({load_enable, save_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_enables load=%b save=%b required 0", load_enable, save_enable);
    end
    vectors++;
    if ({xfer_count, last_value} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_regs count=%h last=%h required 00 00", xfer_count, last_value);
    end
    res = 1'b0;
  endtask

  task automatic test_reg_move();
    send(3'd0, 3'd2, 1'b1, 8'hA5);
    wait_idle();
    send(3'd2, 3'd4, 1'b0, 8'h00);
    @(negedge clk);
    vectors++;
    if ({load_enable, save_enable, req_ready} !== {6'b000100, 6'b000000, 1'b0}) begin
      miscompares++;
      $display("FAIL move_cycle1 load=%b save=%b ready=%b required 000100 000000 0",
               load_enable, save_enable, req_ready);
    end
    @(negedge clk);
    vectors++;
    if ({load_enable, save_enable} !== {6'b000100, 6'b010000}) begin
      miscompares++;
      $display("FAIL move_cycle2 load=%b save=%b required 000100 010000",
               load_enable, save_enable);
    end
    @(negedge clk);
    vectors++;
    if ({load_enable, save_enable, done} !== {12'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL move_cycle3 load=%b save=%b done=%b required 0 0 1",
               load_enable, save_enable, done);
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, xfer_count, last_value} !== {1'b1, 8'd2, 8'hA5}) begin
      miscompares++;
      $display("FAIL move_cycle4 ready=%b count=%0d last=%h required 1 2 a5",
               req_ready, xfer_count, last_value);
    end
    send(3'd4, 3'd4, 1'b0, 8'h00);
    wait_idle();
  endtask

  task automatic test_imm();
    send(3'd5, 3'd0, 1'b1, 8'h3C);
    @(negedge clk);
    vectors++;
    if ({bus_drive, load_enable, save_enable} !== {8'h3C, 6'b0, 6'b0}) begin
      miscompares++;
      $display("FAIL imm_cycle1 drive=%h load=%b save=%b required 3c 0 0",
               bus_drive, load_enable, save_enable);
    end
    @(negedge clk);
    vectors++;
    if ({bus_drive, load_enable, save_enable} !== {8'h3C, 6'b0, 6'b000001}) begin
      miscompares++;
      $display("FAIL imm_cycle2 drive=%h load=%b save=%b required 3c 0 000001",
               bus_drive, load_enable, save_enable);
    end
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd4) begin
      miscompares++;
      $display("FAIL imm_count got %0d required 4", xfer_count);
    end
  endtask

  task automatic test_error();
    send(3'd0, 3'd7, 1'b0, 8'h00);
    @(negedge clk);
    vectors++;
    if ({error, done, load_enable, save_enable} !== {1'b1, 1'b0, 12'b0}) begin
      miscompares++;
      $display("FAIL err_cycle1 error=%b done=%b load=%b save=%b required 1 0 0 0",
               error, done, load_enable, save_enable);
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, error, xfer_count} !== {1'b1, 1'b0, 8'd4}) begin
      miscompares++;
      $display("FAIL err_cycle2 ready=%b error=%b count=%0d required 1 0 4",
               req_ready, error, xfer_count);
    end
    send(3'd6, 3'd1, 1'b0, 8'h00);
    send(3'd7, 3'd1, 1'b1, 8'h5A);
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd5) begin
      miscompares++;
      $display("FAIL err_count got %0d required 5", xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] srcs [3] = '{3'd0, 3'd1, 3'd0};
    logic [2:0] dsts [3] = '{3'd1, 3'd3, 3'd5};
    logic       imms [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] vals [3] = '{8'h11, 8'h00, 8'h77};
    int acc [3];
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_src    = srcs[k];
      req_dst    = dsts[k];
      req_imm_en = imms[k];
      req_imm    = vals[k];
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      push_exp(srcs[k], dsts[k], imms[k], vals[k]);
      #1 acc[k] = cyc;
    end
    req_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      vectors++;
      if (acc[k] - acc[k-1] !== 4) begin
        miscompares++;
        $display("FAIL b2b_spacing[%0d] got %0d cycles required 4", k, acc[k] - acc[k-1]);
      end
    end
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd8) begin
      miscompares++;
      $display("FAIL b2b_count got %0d required 8", xfer_count);
    end
  endtask

  task automatic test_reset_mid();
    send(3'd3, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (save_enable !== 6'b000100) begin
      miscompares++;
      $display("FAIL mid_write_save got %b required 000100", save_enable);
    end
    #1 res = 1'b1;
    #1;
    vectors++;
    if ({load_enable, save_enable, xfer_count, done} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset load=%b save=%b count=%0d done=%b required all 0",
               load_enable, save_enable, xfer_count, done);
    end
    clear_model();
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    repeat (4) @(negedge clk);
    send(3'd0, 3'd1, 1'b1, 8'hC3);
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd1) begin
      miscompares++;
      $display("FAIL post_reset_count got %0d required 1", xfer_count);
    end
  endtask

  task automatic test_wrap();
    res = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 255; i++) send(3'd0, 3'(i % 6), 1'b1, 8'(i));
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd255) begin
      miscompares++;
      $display("FAIL wrap_pre got %0d required 255", xfer_count);
    end
    send(3'd0, 3'd2, 1'b1, 8'hEE);
    wait_idle();
    vectors++;
    if (xfer_count !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_post got %0d required 0", xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_reg_move();
    test_imm();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
